axi3_hp_slave_mem: RTL and testbench
====================================

Name: axi3_hp_slave_mem

Overview:
- Word-addressed AXI3 slave memory that consumes the transactions issued by the HP-port command stimulator.
- Sits directly downstream of the stimulator: bench target in simulation, scratch RAM on fabric.
- Services one transaction at a time, FIXED/INCR/WRAP bursts up to 16 beats, with per-transaction ID echo and OKAY/SLVERR responses.

Parameters:
- DEPTH, 256: memory depth in 32-bit words; power of 2; byte range 0 to 4*DEPTH-1.
- ID_WIDTH, 6: width of the awid/wid/bid/arid/rid fields.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- awvalid/awready  in/out  1/1  write-address handshake
- awid  in  ID_WIDTH  write ID
- awaddr  in  32  byte address
- awlen  in  4  beats-1
- awsize  in  3  must be 3'b010
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- wvalid/wready  in/out  1/1  write-data handshake
- wid  in  ID_WIDTH  AXI3 write-data ID
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wlast  in  1  final write beat marker
- bvalid/bready  out/in  1/1  write-response handshake
- bid  out  ID_WIDTH  echoed awid
- bresp  out  2  00 OKAY, 10 SLVERR
- arvalid/arready  in/out  1/1  read-address handshake
- arid  in  ID_WIDTH  read ID
- araddr  in  32  byte address
- arlen  in  4  beats-1
- arsize  in  3  must be 3'b010
- arburst  in  2  burst type, encoding as awburst
- rvalid/rready  out/in  1/1  read-data handshake
- rid  out  ID_WIDTH  echoed arid
- rdata  out  32  read data
- rresp  out  2  00 OKAY, 10 SLVERR
- rlast  out  1  final read beat marker
- Lock/cache/prot/qos inputs are not ported.

Behaviour:
- Reset: reset, synchronous, active-high; clock clock. While reset is high, every ready and valid output is 0; bid, rid, rdata, bresp, rresp and rlast are 0. State goes to IDLE. Memory contents are not cleared.
- A reset asserted mid-burst aborts the transaction; beats already written persist.
- States: IDLE, WDATA, WRESP, RFETCH, RDATA.
- IDLE readies:
  - arready=1.
  - awready=!arvalid, so a read wins over a simultaneous write.
  - wready=awvalid&&!arvalid: the first W beat may be accepted in the same cycle as AW.
- AR handshake: latch ID, address, len, burst -> RFETCH.
- AW handshake:
  - Latch ID, address, len, burst; beat counter = 0.
  - If a W beat is accepted the same cycle and len==0 -> WRESP, otherwise -> WDATA.
- WDATA: wready=1. Each beat writes the enabled bytes, then advances the address and the beat counter. The beat with counter==len goes to WRESP.
- WRESP: bvalid=1 with bid=latched awid. Hold bvalid until bready, then -> IDLE. bvalid rises the cycle after the last W handshake.
- Read timing:
  - RFETCH: one-cycle synchronous RAM read -> RDATA.
  - RDATA: rvalid=1, rid=latched arid, rlast=(beat==len). Hold until rready.
  - After rready: the last beat goes to IDLE; any other beat advances the address and goes to RFETCH.
  - First rvalid is 2 cycles after the AR handshake; one bubble cycle between beats.
- Address advance:
  - FIXED: unchanged.
  - INCR: +4.
  - WRAP: +4 within an aligned window of (len+1)*4 bytes. len must be 1, 3, 7 or 15.
- SLVERR conditions, sticky for the whole transaction:
  - Beat address >= 4*DEPTH.
  - size != 3'b010.
  - burst==11.
  - WRAP with an illegal len.
  - Writes only: wid != awid, or wlast != (beat==len).
- SLVERR beats are not written; SLVERR reads return rdata=0 with rresp=10. Otherwise the response is OKAY.
- A transaction always ends on the len count regardless of wlast.
- Address decode uses addr[log2(DEPTH)+1:2]; addr[1:0] is ignored.
- rdata, rid, rresp and rlast stay stable while rvalid && !rready.

Optional Feature:
- Macro AXI_SLAVE_STALL_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1, reloaded on reset) advances every cycle. When LFSR[0]==1, every ready output is forced to 0 and no new bvalid/rvalid assertion begins. An already-asserted valid stays asserted.
- Not defined: no LFSR; timing exactly as above.

Test Plan:
- Single write: awaddr=0x10, awlen=0, wdata=0xDEADBEEF, wstrb=1111, awid=5, all same cycle -> bvalid the next cycle, bid=5, bresp=00. Then read 0x10 with arid=3 -> rvalid 2 cycles after AR, rdata=0xDEADBEEF, rid=3, rlast=1.
- Byte strobes: write 0x11223344 to 0x20, then wstrb=0010 data 0xFFFFFFFF -> read returns 0x1122FF44.
- INCR burst: write 4 beats to 0x40, awlen=3, data 1..4 -> one B, OKAY. WRAP read at 0x48, arlen=3 -> rdata 3,4,1,2 with rlast only on the 4th beat.
- Errors: write to 0x400 with DEPTH=256 -> bresp=10, memory unchanged. Read arburst=11 -> rresp=10, rdata=0. Write with wid!=awid -> bresp=10.
- Arbitration and backpressure: arvalid and awvalid in the same cycle -> AR accepted first, awready=0. Then rready=0 for 5 cycles -> rdata held stable and rvalid held. The write is accepted after the read completes.
- Mid-burst reset during a 16-beat write after beat 3 -> all outputs 0, state IDLE. Beats 0-2 readable afterwards; no bvalid is ever issued for that burst.

Source files
------------

// File: rtl/axi3_hp_slave_mem.sv
// axi3_hp_slave_mem: word-addressed AXI3 slave RAM, one FIXED/INCR/WRAP transaction at a time.
// Define AXI_SLAVE_STALL_EN to add LFSR-driven random backpressure on the ready outputs.
module axi3_hp_slave_mem #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned ID_WIDTH = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_WIDTH-1:0] awid,
    input  logic [31:0]         awaddr,
    input  logic [3:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                wvalid,
    output logic                wready,
    input  logic [ID_WIDTH-1:0] wid,
    input  logic [31:0]         wdata,
    input  logic [3:0]          wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [ID_WIDTH-1:0] bid,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ID_WIDTH-1:0] arid,
    input  logic [31:0]         araddr,
    input  logic [3:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    output logic                rvalid,
    input  logic                rready,
    output logic [ID_WIDTH-1:0] rid,
    output logic [31:0]         rdata,
    output logic [1:0]          rresp,
    output logic                rlast
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WDATA, WRESP, RFETCH, RDATA} state_t;

    state_t              state, next_state;
    logic [31:0]         mem [DEPTH];
    logic [ID_WIDTH-1:0] id_r;
    logic [31:0]         addr_r;
    logic [3:0]          len_r, beat_r;
    logic [1:0]          burst_r;
    logic                err_r;
    logic [31:0]         rdata_r;
    logic [1:0]          rresp_r, bresp_r;
    logic                rlast_r;
    logic                stall;
    logic                ar_rdy, aw_rdy, w_rdy, ar_hs, aw_hs, w_hs;
    logic [ID_WIDTH-1:0] cur_id;
    logic [31:0]         cur_addr;
    logic [3:0]          cur_len, cur_beat;
    logic [1:0]          cur_burst;
    logic                cur_err, w_err, w_final;

    function automatic logic txn_err(input logic [2:0] size, input logic [1:0] burst, input logic [3:0] len);
        return (size != 3'b010) || (burst == 2'b11) ||
               (burst == 2'b10 && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
    endfunction

    function automatic logic oob(input logic [31:0] addr);
        return addr[31:AW+2] != '0;
    endfunction

    // WRAP window is (len+1)*4 bytes; len is 2^n-1, so {len,2'b11} is the offset mask.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst);
        logic [31:0] mask;
        mask = {26'd0, len, 2'b11};
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | ((addr + 32'd4) & mask);
            default: return addr + 32'd4;
        endcase
    endfunction

`ifdef AXI_SLAVE_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clock) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);
    end
    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    // In IDLE the write beat checks use the live AW fields, since beat 0 may ride with AW.
    always_comb begin
        cur_id    = (state == IDLE) ? awid    : id_r;
        cur_addr  = (state == IDLE) ? awaddr  : addr_r;
        cur_len   = (state == IDLE) ? awlen   : len_r;
        cur_burst = (state == IDLE) ? awburst : burst_r;
        cur_beat  = (state == IDLE) ? 4'd0    : beat_r;
        cur_err   = (state == IDLE) ? txn_err(awsize, awburst, awlen) : err_r;
        w_final   = (cur_beat == cur_len);
        w_err     = cur_err || oob(cur_addr) || (wid != cur_id) || (wlast != w_final);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        ar_rdy     = 1'b0;
        aw_rdy     = 1'b0;
        w_rdy      = 1'b0;
        case (state)
            IDLE: begin
                ar_rdy = 1'b1;
                aw_rdy = !arvalid;
                w_rdy  = awvalid && !arvalid;
            end
            WDATA:   w_rdy = 1'b1;
            default: ;
        endcase
        if (reset || stall) begin
            ar_rdy = 1'b0;
            aw_rdy = 1'b0;
            w_rdy  = 1'b0;
        end
        ar_hs = arvalid && ar_rdy;
        aw_hs = awvalid && aw_rdy;
        w_hs  = wvalid && w_rdy;
        case (state)
            IDLE: begin
                if (ar_hs)      next_state = RFETCH;
                else if (aw_hs) next_state = (w_hs && w_final) ? WRESP : WDATA;
            end
            WDATA:  if (w_hs && w_final) next_state = WRESP;
            WRESP:  if (bready) next_state = IDLE;
            RFETCH: if (!stall) next_state = RDATA;
            RDATA:  if (rready) next_state = rlast_r ? IDLE : RFETCH;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_hs && !w_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[cur_addr[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            id_r    <= '0;
            addr_r  <= '0;
            len_r   <= '0;
            beat_r  <= '0;
            burst_r <= '0;
            err_r   <= 1'b0;
            rdata_r <= '0;
            rresp_r <= OKAY;
            bresp_r <= OKAY;
            rlast_r <= 1'b0;
        end else if (ar_hs) begin
            id_r    <= arid;
            addr_r  <= araddr;
            len_r   <= arlen;
            burst_r <= arburst;
            beat_r  <= '0;
            err_r   <= txn_err(arsize, arburst, arlen);
        end else if (aw_hs || w_hs) begin
            id_r    <= cur_id;
            len_r   <= cur_len;
            burst_r <= cur_burst;
            if (w_hs) begin
                err_r  <= w_err;
                addr_r <= next_addr(cur_addr, cur_len, cur_burst);
                beat_r <= cur_beat + 4'd1;
                if (w_final) bresp_r <= w_err ? SLVERR : OKAY;
            end else begin
                err_r  <= cur_err;
                addr_r <= cur_addr;
                beat_r <= '0;
            end
        end else if (state == RFETCH) begin
            err_r   <= err_r || oob(addr_r);
            rdata_r <= (err_r || oob(addr_r)) ? '0 : mem[addr_r[AW+1:2]];
            rresp_r <= (err_r || oob(addr_r)) ? SLVERR : OKAY;
            rlast_r <= (beat_r == len_r);
        end else if (state == RDATA && rready && !rlast_r) begin
            addr_r <= next_addr(addr_r, len_r, burst_r);
            beat_r <= beat_r + 4'd1;
        end
    end

    assign arready = ar_rdy;
    assign awready = aw_rdy;
    assign wready  = w_rdy;
    assign bvalid  = !reset && (state == WRESP);
    assign rvalid  = !reset && (state == RDATA);
    assign bid     = reset ? '0 : id_r;
    assign rid     = reset ? '0 : id_r;
    assign bresp   = reset ? OKAY : bresp_r;
    assign rdata   = reset ? '0 : rdata_r;
    assign rresp   = reset ? OKAY : rresp_r;
    assign rlast   = !reset && rlast_r;
endmodule

// File: tb/tb_axi3_hp_slave_mem.sv
// Directed self-checking bench for axi3_hp_slave_mem (default build, DEPTH=256, ID_WIDTH=6).
module tb_axi3_hp_slave_mem;
    logic        clock = 1'b0;
    logic        reset;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [5:0]  awid, wid, bid, arid, rid;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  awlen, wstrb, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, bresp, arburst, rresp;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [5:0]  rd_id   [16];
    int unsigned rd_wait [16];
    logic [1:0]  w_resp;
    logic [5:0]  w_bid;
    int unsigned w_wait;
    logic        seen_b;

    axi3_hp_slave_mem #(.DEPTH(256), .ID_WIDTH(6)) dut (
        .clock(clock), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [3:0] len, input logic [1:0] burst,
                             input logic [5:0] id, input logic [5:0] w_id, input logic [3:0] strb,
                             input logic [31:0] d0);
        int unsigned t;
        awvalid = 1'b1; awaddr = a; awlen = len; awburst = burst; awsize = 3'b010; awid = id;
        for (int unsigned i = 0; i <= 32'(len); i++) begin
            wvalid = 1'b1; wid = w_id; wdata = d0 + i; wstrb = strb; wlast = (i == 32'(len));
            t = 0;
            @(negedge clock);
            while (!wready && t < 20) begin t++; @(negedge clock); end
            check("w_ready", 32'(wready), 32'd1);
            @(posedge clock); #1;
            awvalid = 1'b0;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        t = 0;
        @(negedge clock);
        while (!bvalid && t < 20) begin t++; @(negedge clock); end
        check("b_valid", 32'(bvalid), 32'd1);
        w_resp = bresp; w_bid = bid; w_wait = t;
        @(posedge clock); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [3:0] len, input logic [1:0] burst,
                            input logic [5:0] id);
        int unsigned t;
        arvalid = 1'b1; araddr = a; arlen = len; arburst = burst; arsize = 3'b010; arid = id;
        rready = 1'b1;
        t = 0;
        @(negedge clock);
        while (!arready && t < 20) begin t++; @(negedge clock); end
        check("ar_ready", 32'(arready), 32'd1);
        @(posedge clock); #1;
        arvalid = 1'b0;
        for (int unsigned i = 0; i <= 32'(len); i++) begin
            t = 0;
            @(negedge clock);
            while (!rvalid && t < 20) begin t++; @(negedge clock); end
            check("r_valid", 32'(rvalid), 32'd1);
            rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast; rd_id[i] = rid; rd_wait[i] = t;
            @(posedge clock); #1;
        end
        rready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        awvalid = 1'b1; arvalid = 1'b1; wvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        awid = '0; wid = '0; arid = '0; awaddr = '0; araddr = '0; wdata = '0;
        awlen = '0; arlen = '0; wstrb = '0; wlast = 1'b0;
        awsize = 3'b010; arsize = 3'b010; awburst = 2'b01; arburst = 2'b01;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_ctrl", {26'd0, arready, awready, wready, bvalid, rvalid, rlast}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ids_resp", {16'd0, bid, rid, bresp, rresp}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0; awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0;
        @(negedge clock);
        check("idle_ready", {30'd0, arready, awready}, 32'd3);
        @(posedge clock); #1;

        // background words used by later checks
        axi_write(32'h0, 4'd0, 2'b01, 6'd1, 6'd1, 4'hF, 32'h0BADF00D);
        axi_write(32'h8C, 4'd0, 2'b01, 6'd1, 6'd1, 4'hF, 32'h5555AAAA);

        // single write + read
        axi_write(32'h10, 4'd0, 2'b01, 6'd5, 6'd5, 4'hF, 32'hDEADBEEF);
        check("single_b_lat", w_wait, 32'd0);
        check("single_bid", 32'(w_bid), 32'd5);
        check("single_bresp", 32'(w_resp), 32'd0);
        axi_read(32'h10, 4'd0, 2'b01, 6'd3);
        check("single_r_lat", rd_wait[0], 32'd1);
        check("single_rdata", rd_data[0], 32'hDEADBEEF);
        check("single_rid", 32'(rd_id[0]), 32'd3);
        check("single_rlast", 32'(rd_last[0]), 32'd1);
        check("single_rresp", 32'(rd_resp[0]), 32'd0);

        // byte strobes
        axi_write(32'h20, 4'd0, 2'b01, 6'd2, 6'd2, 4'hF, 32'h11223344);
        axi_write(32'h20, 4'd0, 2'b01, 6'd2, 6'd2, 4'b0010, 32'hFFFFFFFF);
        axi_read(32'h20, 4'd0, 2'b01, 6'd2);
        check("strb_rdata", rd_data[0], 32'h1122FF44);

        // INCR write, WRAP read
        axi_write(32'h40, 4'd3, 2'b01, 6'd6, 6'd6, 4'hF, 32'd1);
        check("incr_bresp", 32'(w_resp), 32'd0);
        axi_read(32'h48, 4'd3, 2'b10, 6'd8);
        check("wrap_d0", rd_data[0], 32'd3);
        check("wrap_d1", rd_data[1], 32'd4);
        check("wrap_d2", rd_data[2], 32'd1);
        check("wrap_d3", rd_data[3], 32'd2);
        check("wrap_last", {28'd0, rd_last[3], rd_last[2], rd_last[1], rd_last[0]}, 32'b1000);
        check("wrap_gap", rd_wait[2], 32'd1);

        // error responses
        axi_write(32'h400, 4'd0, 2'b01, 6'd2, 6'd2, 4'hF, 32'h12345678);
        check("oob_bresp", 32'(w_resp), 32'd2);
        axi_read(32'h0, 4'd0, 2'b01, 6'd1);
        check("oob_alias_unchanged", rd_data[0], 32'h0BADF00D);
        axi_read(32'h400, 4'd0, 2'b01, 6'd1);
        check("oob_rd_rresp", 32'(rd_resp[0]), 32'd2);
        check("oob_rd_rdata", rd_data[0], 32'd0);
        axi_read(32'h10, 4'd0, 2'b11, 6'd4);
        check("rsvd_rresp", 32'(rd_resp[0]), 32'd2);
        check("rsvd_rdata", rd_data[0], 32'd0);
        axi_write(32'h14, 4'd0, 2'b01, 6'd4, 6'd6, 4'hF, 32'h77);
        check("wid_bresp", 32'(w_resp), 32'd2);

        // arbitration and read backpressure
        arvalid = 1'b1; araddr = 32'h10; arlen = 4'd0; arburst = 2'b01; arsize = 3'b010; arid = 6'd7;
        awvalid = 1'b1; awaddr = 32'h30; awlen = 4'd0; awburst = 2'b01; awsize = 3'b010; awid = 6'd11;
        wvalid = 1'b1; wid = 6'd11; wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1'b1; rready = 1'b0;
        @(negedge clock);
        check("arb_ready", {29'd0, arready, awready, wready}, 32'b100);
        @(posedge clock); #1;
        arvalid = 1'b0;
        @(negedge clock);
        check("arb_aw_blocked", 32'(awready), 32'd0);
        @(posedge clock); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_rvalid", 32'(rvalid), 32'd1);
            check("bp_rdata", rdata, 32'hDEADBEEF);
            @(posedge clock); #1;
        end
        check("bp_rid", 32'(rid), 32'd7);
        rready = 1'b1;
        @(negedge clock);
        check("bp_rlast", 32'(rlast), 32'd1);
        @(posedge clock); #1;
        rready = 1'b0;
        @(negedge clock);
        check("arb_aw_after", {30'd0, awready, wready}, 32'b11);
        @(posedge clock); #1;
        awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        @(negedge clock);
        check("arb_b", {24'd0, bvalid, bid, bresp}, {24'd0, 1'b1, 6'd11, 2'b00});
        @(posedge clock); #1;
        bready = 1'b0;
        axi_read(32'h30, 4'd0, 2'b01, 6'd1);
        check("arb_write_data", rd_data[0], 32'hCAFEF00D);

        // reset in the middle of a 16-beat write
        awvalid = 1'b1; awaddr = 32'h80; awlen = 4'd15; awburst = 2'b01; awsize = 3'b010; awid = 6'd9;
        for (int unsigned i = 0; i < 3; i++) begin
            wvalid = 1'b1; wid = 6'd9; wdata = 32'hA0 + i; wstrb = 4'hF; wlast = 1'b0;
            @(negedge clock);
            check("mb_wready", 32'(wready), 32'd1);
            @(posedge clock); #1;
            awvalid = 1'b0;
        end
        wdata = 32'hA3; reset = 1'b1;
        @(negedge clock);
        check("mb_rst_ctrl", {26'd0, arready, awready, wready, bvalid, rvalid, rlast}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0; wvalid = 1'b0; bready = 1'b1; seen_b = 1'b0;
        @(negedge clock);
        check("mb_idle_ready", {30'd0, arready, awready}, 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            seen_b = seen_b | bvalid;
        end
        check("mb_no_bvalid", 32'(seen_b), 32'd0);
        @(posedge clock); #1;
        bready = 1'b0;
        axi_read(32'h80, 4'd3, 2'b01, 6'd1);
        check("mb_d0", rd_data[0], 32'hA0);
        check("mb_d1", rd_data[1], 32'hA1);
        check("mb_d2", rd_data[2], 32'hA2);
        check("mb_d3_untouched", rd_data[3], 32'h5555AAAA);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
